// File: rtl/demux_1_8_seq.sv
// Sequential 1:8 demultiplexer: assembles a serial bit stream into 8-bit words with valid/ready on both sides.
// Optional macro DEMUX_MSB_FIRST_EN selects MSB-first slot mapping (default build is LSB-first).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// a source holds its data stable while valid=1 and ready=0.
module demux_1_8_seq #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hyrja,
    input  logic              hyrja_valid,
    output logic              hyrja_ready,
    input  logic              pastro,
    output logic [SEL_W-1:0]  seleksioni,
    output logic [DATA_W-1:0] dalja,
    output logic              dalja_valid,
    input  logic              dalja_ready,
    output logic [CNT_W-1:0]  numeruesi
);

    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_dalja;
    logic              r_dalja_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_acc;
    logic              w_take;
    logic              w_last;
    logic              w_complete;
    logic [SEL_W-1:0]  w_slot;
    logic [SEL_W-1:0]  w_first_slot;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_buf_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;

    assign w_last = (r_sel == SEL_W'(DATA_W - 1));

    // Bit position in the output word that the current slot maps to.
`ifdef DEMUX_MSB_FIRST_EN
    assign w_slot       = SEL_W'(DATA_W - 1) - r_sel;
    assign w_first_slot = SEL_W'(DATA_W - 1);
`else
    assign w_slot       = r_sel;
    assign w_first_slot = '0;
`endif

    // Stall only when the final bit would overwrite a word nobody has taken.
    assign hyrja_ready = ~w_last | ~r_dalja_valid | dalja_ready;

    assign w_acc      = hyrja_valid & hyrja_ready;
    assign w_take     = r_dalja_valid & dalja_ready;
    assign w_complete = w_acc & w_last & ~pastro;

    always_comb begin
        w_word         = r_buf;
        w_word[w_slot] = hyrja;
        w_buf_nxt      = r_buf;
        w_sel_nxt      = r_sel;
        if (pastro) begin
            // Resync drops the partial word; a bit accepted alongside starts the new one.
            w_buf_nxt = '0;
            w_sel_nxt = '0;
            if (w_acc) begin
                w_buf_nxt[w_first_slot] = hyrja;
                w_sel_nxt               = SEL_W'(1);
            end
        end else if (w_acc) begin
            w_buf_nxt = w_word;
            w_sel_nxt = r_sel + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_buf <= '0;
        end else begin
            r_sel <= w_sel_nxt;
            r_buf <= w_buf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dalja       <= '0;
            r_dalja_valid <= 1'b0;
        end else if (w_complete) begin
            r_dalja       <= w_word;
            r_dalja_valid <= 1'b1;
        end else if (w_take) begin
            r_dalja_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign seleksioni  = r_sel;
    assign dalja       = r_dalja;
    assign dalja_valid = r_dalja_valid;
    assign numeruesi   = r_cnt;

endmodule

// File: tb/tb_demux_1_8_seq.sv
// Self-checking bench for demux_1_8_seq: directed steps, word scoreboard popped on each output handoff.
module tb_demux_1_8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       hyrja;
    logic       hyrja_valid;
    logic       hyrja_ready;
    logic       pastro;
    logic [2:0] seleksioni;
    logic [7:0] dalja;
    logic       dalja_valid;
    logic       dalja_ready;
    logic [7:0] numeruesi;

    logic [7:0] exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] m_word;
    int         m_idx;
    logic [7:0] m_cnt;
    logic [7:0] cnt_before;
    logic [7:0] w_tmp;
    logic       b_tmp;
    logic [7:0] t1_bits;

`ifdef DEMUX_MSB_FIRST_EN
    localparam logic [7:0] T1_EXP = 8'hB2;
`else
    localparam logic [7:0] T1_EXP = 8'h4D;
`endif

    demux_1_8_seq dut (
        .clk         (clk),
        .rst         (rst),
        .hyrja       (hyrja),
        .hyrja_valid (hyrja_valid),
        .hyrja_ready (hyrja_ready),
        .pastro      (pastro),
        .seleksioni  (seleksioni),
        .dalja       (dalja),
        .dalja_valid (dalja_valid),
        .dalja_ready (dalja_ready),
        .numeruesi   (numeruesi)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int slot_of(input int k);
`ifdef DEMUX_MSB_FIRST_EN
        return 7 - k;
`else
        return k;
`endif
    endfunction

    task automatic model_reset();
        m_word = 8'h00;
        m_idx  = 0;
    endtask

    task automatic model_accept(input logic b);
        m_word[slot_of(m_idx)] = b;
        m_idx++;
        if (m_idx == 8) begin
            exp_q.push_back(m_word);
            model_reset();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hyrja_valid = 1'b0;
        hyrja       = 1'b0;
    endtask

    // Holds the bit valid until accepted (bounded), then records it in the model.
    task automatic send_bit(input logic b);
        int n;
        hyrja       = b;
        hyrja_valid = 1'b1;
        n = 0;
        while (!hyrja_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 8'(hyrja_ready), 8'd1);
        tick();
        model_accept(b);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) send_bit(w[slot_of(k)]);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        hyrja       = 1'b0;
        hyrja_valid = 1'b0;
        pastro      = 1'b0;
        dalja_ready = 1'b0;
        exp_q.delete();
        model_reset();
        m_cnt = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every handoff must match the oldest word the model assembled.
    always @(negedge clk) begin
        if (!rst && dalja_valid && dalja_ready) begin
            check("sb_has_entry", 8'(exp_q.size() != 0), 8'd1);
            if (exp_q.size() != 0) check("sb_word", dalja, exp_q.pop_front());
            m_cnt = m_cnt + 8'd1;
        end
    end

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_dalja", dalja, 8'h00);
        check("rst_valid", 8'(dalja_valid), 8'd0);
        check("rst_sel", 8'(seleksioni), 8'd0);
        check("rst_cnt", numeruesi, 8'h00);
        check("rst_ready", 8'(hyrja_ready), 8'd1);
        tick();
        rst = 1'b0;

        // Basic word: 1,0,1,1,0,0,1,0
        dalja_ready = 1'b1;
        t1_bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) send_bit(t1_bits[i]);
        idle();
        check("t1_valid", 8'(dalja_valid), 8'd1);
        check("t1_dalja", dalja, T1_EXP);
        tick();
        check("t1_valid_pulse", 8'(dalja_valid), 8'd0);
        check("t1_cnt", numeruesi, 8'd1);
        check("t1_dalja_hold", dalja, T1_EXP);

        // Backpressure: A5 pending, next word stalls on its last bit
        dalja_ready = 1'b0;
        send_word(8'hA5);
        idle();
        check("bp_a5", dalja, 8'hA5);
        check("bp_a5_valid", 8'(dalja_valid), 8'd1);
        for (int k = 0; k < 7; k++) send_bit(w_bit(8'h3C, k));
        check("bp_sel7", 8'(seleksioni), 8'd7);
        check("bp_stall", 8'(hyrja_ready), 8'd0);
        hyrja       = w_bit(8'h3C, 7);
        hyrja_valid = 1'b1;
        tick();
        tick();
        check("bp_stall_hold", 8'(hyrja_ready), 8'd0);
        check("bp_sel_hold", 8'(seleksioni), 8'd7);
        check("bp_dalja_hold", dalja, 8'hA5);
        check("bp_valid_hold", 8'(dalja_valid), 8'd1);
        cnt_before  = numeruesi;
        dalja_ready = 1'b1;
        #1;
        check("bp_release_ready", 8'(hyrja_ready), 8'd1);
        tick();
        model_accept(w_bit(8'h3C, 7));
        idle();
        check("bp_new_word", dalja, 8'h3C);
        check("bp_new_valid", 8'(dalja_valid), 8'd1);
        check("bp_cnt_inc", numeruesi, cnt_before + 8'd1);
        tick();
        check("bp_cnt_model", numeruesi, m_cnt);

        // Back-to-back: 16 bits, no bubble
        do_reset();
        dalja_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("b2b_ready", 8'(hyrja_ready), 8'd1);
            send_bit(1'($urandom_range(0, 1)));
        end
        idle();
        tick();
        check("b2b_cnt", numeruesi, 8'd2);
        check("b2b_valid_low", 8'(dalja_valid), 8'd0);
        check("b2b_sb_empty", 8'(exp_q.size()), 8'd0);

        // Resync after a partial word
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        idle();
        check("ps_sel5", 8'(seleksioni), 8'd5);
        pastro = 1'b1;
        tick();
        pastro = 1'b0;
        model_reset();
        check("ps_sel0", 8'(seleksioni), 8'd0);
        check("ps_no_word", 8'(dalja_valid), 8'd0);
        send_word(8'hFF);
        idle();
        check("ps_ff", dalja, 8'hFF);
        tick();

        // Resync together with an accepted bit at slot 7
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        check("ps7_sel", 8'(seleksioni), 8'd7);
        hyrja       = 1'b1;
        hyrja_valid = 1'b1;
        pastro      = 1'b1;
        tick();
        pastro = 1'b0;
        idle();
        model_reset();
        model_accept(1'b1);
        check("ps7_no_valid", 8'(dalja_valid), 8'd0);
        check("ps7_sel1", 8'(seleksioni), 8'd1);
        tick();
        check("ps7_still_no_valid", 8'(dalja_valid), 8'd0);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        idle();
        check("ps7_word_valid", 8'(dalja_valid), 8'd1);
        tick();

        // Async reset mid-word with a pending output
        dalja_ready = 1'b0;
        w_tmp = 8'($urandom_range(0, 255));
        send_word(w_tmp);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        idle();
        check("ar_pre_sel", 8'(seleksioni), 8'd4);
        check("ar_pre_valid", 8'(dalja_valid), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_dalja", dalja, 8'h00);
        check("ar_valid", 8'(dalja_valid), 8'd0);
        check("ar_sel", 8'(seleksioni), 8'd0);
        check("ar_cnt", numeruesi, 8'h00);
        check("ar_ready", 8'(hyrja_ready), 8'd1);
        exp_q.delete();
        model_reset();
        m_cnt = 8'h00;
        tick();
        rst = 1'b0;

        // Counter wrap after 256 words
        dalja_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w_tmp = 8'($urandom_range(0, 255));
            send_word(w_tmp);
            if (i == 254) begin
                idle();
                tick();
                check("wrap_255", numeruesi, 8'd255);
            end
        end
        idle();
        tick();
        check("wrap_cnt0", numeruesi, 8'h00);
        check("wrap_model", numeruesi, m_cnt);
        check("wrap_sb_empty", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic w_bit(input logic [7:0] w, input int k);
        return w[slot_of(k)];
    endfunction

endmodule
